// File: rtl/regfile_pkg.sv
// Shared types and sizing for the 8 x 8-bit register file and the ALU that consumes it.
// The ALU uses reg_data_t for DATA1, DATA2 and RESULT.
package regfile_pkg;

    localparam int REG_DATA_W = 8;
    localparam int REG_ADDR_W = 3;
    localparam int REG_COUNT  = 1 << REG_ADDR_W;
    localparam int REG_CNT_W  = 8;

    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: register mux, valid lookup and, when
// REG_WRITE_BYPASS_EN is defined, forwarding of the in-flight write data.
module reg_file_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [(1<<ADDR_W)-1:0]             valid,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_valid
);

`ifdef REG_WRITE_BYPASS_EN
    // wr_en arrives already qualified by reset, so nothing is forwarded during reset.
    always_comb begin
        rd_data  = regs[rd_addr];
        rd_valid = valid[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data  = wr_data;
            rd_valid = 1'b1;
        end
    end
`else
    always_comb begin
        rd_data  = regs[rd_addr];
        rd_valid = valid[rd_addr];
    end

    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// 8 x 8-bit register file: two combinational read ports, one clocked write port,
// per-register written flags and a saturating write counter. Option: REG_WRITE_BYPASS_EN.
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = REG_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1_VALID,
    output logic              OUT2_VALID,
    output logic [CNT_W-1:0]  WRITE_CNT
);

    localparam int COUNT = 1 << ADDR_W;

    logic [COUNT-1:0][DATA_W-1:0] regs;
    logic [COUNT-1:0]             valid;
    logic [CNT_W-1:0]             write_cnt;
    logic                         wr_live;

    // NOTE: the array is reset because the read ports must show 0 during and after reset;
    // a storage array that only needs a defined value after first write would not be.
    // NOTE: all state here uses non-blocking assignments so every read port and the
    // counter see one consistent pre-edge snapshot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs      <= '0;
            valid     <= '0;
            write_cnt <= '0;
        end else if (WRITE) begin
            regs[INADDRESS]  <= IN;
            valid[INADDRESS] <= 1'b1;
            if (write_cnt != '1) begin
                write_cnt <= write_cnt + CNT_W'(1);
            end
        end
    end

    assign wr_live   = WRITE & RESET_N;
    assign WRITE_CNT = write_cnt;

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .regs     (regs),
        .valid    (valid),
        .rd_addr  (OUT1ADDRESS),
        .wr_en    (wr_live),
        .wr_addr  (INADDRESS),
        .wr_data  (IN),
        .rd_data  (OUT1),
        .rd_valid (OUT1_VALID)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .regs     (regs),
        .valid    (valid),
        .rd_addr  (OUT2ADDRESS),
        .wr_en    (wr_live),
        .wr_addr  (INADDRESS),
        .wr_data  (IN),
        .rd_data  (OUT2),
        .rd_valid (OUT2_VALID)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based reference model; handles both REG_WRITE_BYPASS_EN builds.
module tb_reg_file;
    import regfile_pkg::*;

    logic                 CLK = 1'b0;
    logic                 RESET_N;
    reg_data_t            IN;
    reg_addr_t            INADDRESS;
    logic                 WRITE;
    reg_addr_t            OUT1ADDRESS;
    reg_addr_t            OUT2ADDRESS;
    reg_data_t            OUT1;
    reg_data_t            OUT2;
    logic                 OUT1_VALID;
    logic                 OUT2_VALID;
    logic [REG_CNT_W-1:0] WRITE_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents, written flags, total committed writes.
    int model_mem [REG_COUNT];
    bit model_vld [REG_COUNT];
    int model_writes;

`ifdef REG_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .OUT1_VALID  (OUT1_VALID),
        .OUT2_VALID  (OUT2_VALID),
        .WRITE_CNT   (WRITE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < REG_COUNT; i++) begin
            model_mem[i] = 0;
            model_vld[i] = 1'b0;
        end
        model_writes = 0;
    endtask

    function automatic int exp_data(input reg_addr_t a);
        if (!RESET_N) return 0;
        if (BYPASS && WRITE && a == INADDRESS) return int'(IN);
        return model_mem[a];
    endfunction

    function automatic int exp_valid(input reg_addr_t a);
        if (!RESET_N) return 0;
        if (BYPASS && WRITE && a == INADDRESS) return 1;
        return model_vld[a] ? 1 : 0;
    endfunction

    function automatic int exp_cnt();
        if (!RESET_N) return 0;
        return (model_writes > 255) ? 255 : model_writes;
    endfunction

    // One rising edge; the model commits what the DUT should commit, then settle 1 ns.
    task automatic step();
        @(posedge CLK);
        if (RESET_N === 1'b1 && WRITE === 1'b1) begin
            model_mem[INADDRESS] = int'(IN);
            model_vld[INADDRESS] = 1'b1;
            model_writes++;
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_out1"},  32'(OUT1),       32'(exp_data(OUT1ADDRESS)));
        check({tag, "_out2"},  32'(OUT2),       32'(exp_data(OUT2ADDRESS)));
        check({tag, "_vld1"},  32'(OUT1_VALID), 32'(exp_valid(OUT1ADDRESS)));
        check({tag, "_vld2"},  32'(OUT2_VALID), 32'(exp_valid(OUT2ADDRESS)));
        check({tag, "_cnt"},   32'(WRITE_CNT),  32'(exp_cnt()));
    endtask

    task automatic set_write(input logic w, input reg_addr_t a, input reg_data_t d);
        WRITE     = w;
        INADDRESS = a;
        IN        = d;
    endtask

    initial begin
        model_clear();
        RESET_N     = 1'b0;
        set_write(1'b1, 3'd0, 8'hFF);
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd7;

        // Reset held across two edges with a write pending.
        repeat (2) step();
        check("rst_out1", 32'(OUT1), 0);
        check("rst_out2", 32'(OUT2), 0);
        check("rst_vld1", 32'(OUT1_VALID), 0);
        check("rst_vld2", 32'(OUT2_VALID), 0);
        check("rst_cnt",  32'(WRITE_CNT), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        WRITE   = 1'b0;
        step();
        for (int i = 0; i < REG_COUNT; i++) begin
            OUT1ADDRESS = reg_addr_t'(i);
            #1;
            check("post_rst_reg", 32'(OUT1), 0);
        end

        // Basic write/read on consecutive edges.
        set_write(1'b1, 3'd1, 8'd25);
        step();
        set_write(1'b1, 3'd2, 8'd41);
        step();
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd1;
        OUT2ADDRESS = 3'd2;
        #1;
        check("basic_out1", 32'(OUT1), 25);
        check("basic_out2", 32'(OUT2), 41);
        check("basic_vld1", 32'(OUT1_VALID), 1);
        check("basic_vld2", 32'(OUT2_VALID), 1);
        check("basic_cnt",  32'(WRITE_CNT), 2);

        // Same-cycle read and write of r3.
        set_write(1'b1, 3'd3, 8'd14);
        step();
        set_write(1'b1, 3'd3, 8'd53);
        OUT1ADDRESS = 3'd3;
        #1;
        check("rw_pre_out1", 32'(OUT1), BYPASS ? 53 : 14);
        check_ports("rw_pre");
        step();
        WRITE = 1'b0;
        #1;
        check("rw_post_out1", 32'(OUT1), 53);

        // Both ports on the same register; unwritten register reads 0 / invalid.
        set_write(1'b1, 3'd5, 8'd222);
        step();
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd5;
        OUT2ADDRESS = 3'd5;
        #1;
        check("dual_out1", 32'(OUT1), 222);
        check("dual_out2", 32'(OUT2), 222);
        OUT2ADDRESS = 3'd6;
        #1;
        check("unwr_out2", 32'(OUT2), 0);
        check("unwr_vld2", 32'(OUT2_VALID), 0);

        // Asynchronous reset between edges with a write pending.
        set_write(1'b1, 3'd4, 8'd96);
        step();
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd4;
        #1;
        check("async_pre_out1", 32'(OUT1), 96);
        set_write(1'b1, 3'd4, 8'd77);
        #1;
        RESET_N = 1'b0;
        model_clear();
        #1;
        check("async_out1", 32'(OUT1), 0);
        check("async_vld1", 32'(OUT1_VALID), 0);
        check("async_cnt",  32'(WRITE_CNT), 0);
        step();
        @(negedge CLK);
        RESET_N = 1'b1;
        WRITE   = 1'b0;
        #1;
        check("async_rel_out1", 32'(OUT1), 0);
        check("async_rel_cnt",  32'(WRITE_CNT), 0);
        check_ports("async_rel");

        // 300 writes to r7: counter saturates at 255, r7 keeps the last data.
        for (int i = 0; i < 300; i++) begin
            set_write(1'b1, 3'd7, reg_data_t'(i % 256));
            step();
            if (i == 253) check("sat_cnt_254", 32'(WRITE_CNT), 254);
            if (i == 254) check("sat_cnt_255", 32'(WRITE_CNT), 255);
        end
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd7;
        #1;
        check("sat_out1", 32'(OUT1), 43);
        check("sat_cnt",  32'(WRITE_CNT), 255);
        check("sat_vld1", 32'(OUT1_VALID), 1);

        // Fresh reset, then randomized traffic against the model.
        RESET_N = 1'b0;
        model_clear();
        #1;
        check_ports("rnd_rst");
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 200; i++) begin
            set_write(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, REG_COUNT - 1)),
                      reg_data_t'($urandom_range(0, 255)));
            OUT1ADDRESS = reg_addr_t'($urandom_range(0, REG_COUNT - 1));
            OUT2ADDRESS = (i % 4 == 0) ? INADDRESS : reg_addr_t'($urandom_range(0, REG_COUNT - 1));
            #1;
            check_ports("rnd_pre");
            step();
            check_ports("rnd_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
